// File: rtl/lc3b_dcache.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lc3b_dcache : direct-mapped write-back/write-allocate cache that answers  |
// | 16-bit pipeline requests and moves whole 128-bit lines to/from memory.   |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module lc3b_dcache #(
  parameter int NUM_SETS   = 8,
  parameter int LINE_WORDS = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   mem_address,
  input  logic          mem_read,
  input  logic          mem_write,
  input  logic [1:0]    mem_byte_enable,
  input  logic [15:0]   mem_wdata,
  output logic [15:0]   mem_rdata,
  output logic          mem_resp,
  output logic [15:0]   pmem_address,
  output logic          pmem_read,
  output logic          pmem_write,
  input  logic [127:0]  pmem_rdata,
  output logic [127:0]  pmem_wdata,
  input  logic          pmem_resp
);

  localparam int INDEX_W   = $clog2(NUM_SETS);
  localparam int TAG_W     = 12 - INDEX_W;
  localparam int LINE_BITS = LINE_WORDS * 16;

  typedef enum logic [1:0] {
    S_CHECK     = 2'd0,
    S_WRITEBACK = 2'd1,
    S_FILL      = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [NUM_SETS-1:0]    valid_q, valid_d;
  logic [NUM_SETS-1:0]    dirty_q, dirty_d;
  logic [TAG_W-1:0]       tag_q  [NUM_SETS];
  logic [TAG_W-1:0]       tag_d  [NUM_SETS];
  logic [LINE_BITS-1:0]   data_q [NUM_SETS];
  logic [LINE_BITS-1:0]   data_d [NUM_SETS];

  logic [INDEX_W-1:0]     w_idx;
  logic [TAG_W-1:0]       w_tag;
  logic [2:0]             w_word;
  logic [6:0]             w_bit;
  logic                   w_req;
  logic                   w_hit;
  logic [LINE_BITS-1:0]   w_line;
  logic                   w_unused;

  assign w_idx    = mem_address[3+INDEX_W:4];
  assign w_tag    = mem_address[15:4+INDEX_W];
  assign w_word   = mem_address[3:1];
  assign w_bit    = {w_word, 4'b0000};
  assign w_req    = mem_read | mem_write;
  assign w_line   = data_q[w_idx];
  assign w_hit    = valid_q[w_idx] & (tag_q[w_idx] == w_tag) & w_req;
  // Byte address bit 0 never selects anything in a word-organised line.
  assign w_unused = mem_address[0];

  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    tag_d        = tag_q;
    data_d       = data_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;

    case (state_q)
      S_CHECK: begin
        if (w_hit) begin
          mem_resp  = 1'b1;
          mem_rdata = w_line[w_bit +: 16];
          // Write wins over a simultaneous read; byte mask 00 still marks dirty.
          if (mem_write) begin
            dirty_d[w_idx] = 1'b1;
            if (mem_byte_enable[0]) data_d[w_idx][w_bit +: 8]         = mem_wdata[7:0];
            if (mem_byte_enable[1]) data_d[w_idx][w_bit + 7'd8 +: 8]  = mem_wdata[15:8];
          end
        end else if (w_req) begin
          state_d = (valid_q[w_idx] & dirty_q[w_idx]) ? S_WRITEBACK : S_FILL;
        end
      end

      S_WRITEBACK: begin
        pmem_write   = 1'b1;
        pmem_address = {tag_q[w_idx], w_idx, 4'b0000};
        pmem_wdata   = data_q[w_idx];
        if (pmem_resp) begin
          dirty_d[w_idx] = 1'b0;
          state_d        = S_FILL;
        end
      end

      S_FILL: begin
        pmem_read    = 1'b1;
        pmem_address = {mem_address[15:4], 4'b0000};
        if (pmem_resp) begin
          data_d[w_idx]  = pmem_rdata;
          tag_d[w_idx]   = w_tag;
          valid_d[w_idx] = 1'b1;
          dirty_d[w_idx] = 1'b0;
          state_d        = S_CHECK;
        end
      end

      default: state_d = S_CHECK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CHECK;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  // Tag and data contents are meaningless until valid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_lc3b_dcache.sv
`default_nettype none
// Directed bench for lc3b_dcache: a line-granular memory model answers fills
// and writebacks, and a scoreboard queue holds expected read data.
module tb_lc3b_dcache;

  localparam int LAT = 2;

  logic          clk;
  logic          reset;
  logic [15:0]   mem_address;
  logic          mem_read;
  logic          mem_write;
  logic [1:0]    mem_byte_enable;
  logic [15:0]   mem_wdata;
  logic [15:0]   mem_rdata;
  logic          mem_resp;
  logic [15:0]   pmem_address;
  logic          pmem_read;
  logic          pmem_write;
  logic [127:0]  pmem_rdata;
  logic [127:0]  pmem_wdata;
  logic          pmem_resp;

  lc3b_dcache #(.NUM_SETS(8), .LINE_WORDS(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp),
    .pmem_address    (pmem_address),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .pmem_rdata      (pmem_rdata),
    .pmem_wdata      (pmem_wdata),
    .pmem_resp       (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pmem_img: backing store; gold: what the program should observe.
  logic [127:0] pmem_img [4096];
  logic [127:0] gold     [4096];
  logic [15:0]  exp_q [$];

  int checks = 0;
  int errors = 0;
  int cycles, wb_n, fill_n;
  logic [15:0] wb_addr, fill_addr;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] gold_word(input logic [15:0] addr);
    logic [127:0] line;
    int w;
    line = gold[addr[15:4]];
    w    = int'(addr[3:1]);
    return line[w*16 +: 16];
  endfunction

  task automatic gold_write(input logic [15:0] addr, input logic [1:0] be, input logic [15:0] wd);
    logic [127:0] line;
    int w;
    line = gold[addr[15:4]];
    w    = int'(addr[3:1]);
    if (be[0]) line[w*16 +: 8]     = wd[7:0];
    if (be[1]) line[w*16 + 8 +: 8] = wd[15:8];
    gold[addr[15:4]] = line;
  endtask

  // Issue one request at a negedge and service the memory side until mem_resp.
  task automatic access(input bit wr, input logic [15:0] addr, input logic [1:0] be,
                        input logic [15:0] wd);
    int  n;
    int  lat;
    bit  done;
    @(negedge clk);
    mem_address     = addr;
    mem_read        = !wr;
    mem_write       = wr;
    mem_byte_enable = be;
    mem_wdata       = wd;
    if (wr) gold_write(addr, be, wd);
    else    exp_q.push_back(gold_word(addr));
    n = 0; lat = 0; done = 1'b0;
    wb_n = 0; fill_n = 0; wb_addr = '0; fill_addr = '0;
    while (!done && n < 40) begin
      #1;
      n++;
      check("resp_excl", mem_resp & (pmem_read | pmem_write), 1'b0);
      if (mem_resp) begin
        if (!wr) check("rdata", mem_rdata, exp_q.pop_front());
        done = 1'b1;
      end else begin
        if (pmem_write || pmem_read) begin
          lat++;
          if (lat == LAT) begin
            if (pmem_write) begin
              wb_n++;
              wb_addr = pmem_address;
              check("wb_data", pmem_wdata, gold[pmem_address[15:4]]);
              pmem_img[pmem_address[15:4]] = pmem_wdata;
            end else begin
              fill_n++;
              fill_addr  = pmem_address;
              pmem_rdata = pmem_img[pmem_address[15:4]];
            end
            pmem_resp = 1'b1;
            lat = 0;
          end
        end
        @(negedge clk);
        pmem_resp = 1'b0;
      end
    end
    cycles = n;
    check("timeout", done, 1'b1);
  endtask

  task automatic idle();
    @(negedge clk);
    mem_read  = 1'b0;
    mem_write = 1'b0;
  endtask

  initial begin
    int n;
    logic [127:0] line;
    reset = 1'b1; mem_address = '0; mem_read = 1'b0; mem_write = 1'b0;
    mem_byte_enable = '0; mem_wdata = '0; pmem_rdata = '0; pmem_resp = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      for (int w = 0; w < 8; w++) line[w*16 +: 16] = 16'(i * 8 + w) ^ 16'hA5A5;
      pmem_img[i] = line;
    end
    line = pmem_img[12'h004];
    line[15:0]  = 16'h1234;
    line[63:48] = 16'hBEEF;
    pmem_img[12'h004] = line;
    for (int i = 0; i < 4096; i++) gold[i] = pmem_img[i];

    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_resp",  mem_resp,     1'b0);
    check("rst_pread", pmem_read,    1'b0);
    check("rst_pwrite",pmem_write,   1'b0);
    check("rst_paddr", pmem_address, 16'h0000);
    check("rst_rdata", mem_rdata,    16'h0000);

    // Cold read miss
    access(1'b0, 16'h0040, 2'b00, 16'h0000);
    check("cold_cycles", cycles, 4);
    check("cold_fill_n", fill_n, 1);
    check("cold_fill_a", fill_addr, 16'h0040);
    check("cold_wb_n",   wb_n, 0);

    // Hit in same line
    access(1'b0, 16'h0046, 2'b00, 16'h0000);
    check("hit_cycles", cycles, 1);
    check("hit_fill_n", fill_n, 0);

    // High-byte write hit then readback
    access(1'b1, 16'h0040, 2'b10, 16'hAB99);
    check("bw_cycles", cycles, 1);
    access(1'b0, 16'h0040, 2'b00, 16'h0000);
    check("bw_rd_cycles", cycles, 1);

    // Dirty conflict eviction
    access(1'b0, 16'h00C0, 2'b00, 16'h0000);
    check("evict_cycles", cycles, 6);
    check("evict_wb_n",   wb_n, 1);
    check("evict_wb_a",   wb_addr, 16'h0040);
    check("evict_fill_a", fill_addr, 16'h00C0);
    access(1'b0, 16'h0040, 2'b00, 16'h0000);
    check("refill_cycles", cycles, 4);
    check("refill_wb_n",   wb_n, 0);
    check("refill_fill_a", fill_addr, 16'h0040);

    // Clean eviction then back-to-back hit
    access(1'b0, 16'h0140, 2'b00, 16'h0000);
    check("clean_wb_n",   wb_n, 0);
    check("clean_fill_a", fill_addr, 16'h0140);
    access(1'b0, 16'h0142, 2'b00, 16'h0000);
    check("b2b_cycles", cycles, 1);

    // Empty byte mask still dirties the line
    access(1'b1, 16'h0142, 2'b00, 16'hFFFF);
    check("be00_cycles", cycles, 1);
    access(1'b0, 16'h0142, 2'b00, 16'h0000);
    access(1'b0, 16'h0043, 2'b00, 16'h0000);
    check("be00_wb_n", wb_n, 1);
    check("be00_wb_a", wb_addr, 16'h0140);
    check("be00_cycles_miss", cycles, 6);

    // Low-byte write with odd addresses
    access(1'b1, 16'h0045, 2'b01, 16'h1177);
    access(1'b0, 16'h0044, 2'b00, 16'h0000);
    idle();

    // Reset while a fill is outstanding
    @(negedge clk);
    mem_address = 16'h0020;
    mem_read    = 1'b1;
    n = 0;
    #1;
    while (!pmem_read && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("fill_seen", pmem_read, 1'b1);
    reset    = 1'b1;
    mem_read = 1'b0;
    @(negedge clk);
    #1;
    check("abort_pread",  pmem_read,  1'b0);
    check("abort_pwrite", pmem_write, 1'b0);
    check("abort_resp",   mem_resp,   1'b0);
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) gold[i] = pmem_img[i];
    access(1'b0, 16'h0044, 2'b00, 16'h0000);
    check("post_rst_cycles", cycles, 4);
    check("post_rst_wb_n",   wb_n, 0);
    check("post_rst_fill_a", fill_addr, 16'h0040);
    idle();

    check("sb_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
